barramento_snoop: RTL and testbench

//  Shared snooping bus for the MSI coherence nodes. Arbitrates bus messages issued by

---
 rtl/barramento_pkg.sv | 33 +++
 rtl/arbitro_rr.sv | 42 ++++
 rtl/barramento_snoop.sv | 172 +++++++++++++++++
 tb/tb_barramento_snoop.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barramento_pkg.sv
// Shared codes for the MSI snooping bus: bus messages, memory op, MSI states and bus FSM states.
package barramento_pkg;

    localparam int unsigned MSG_W = 2;

    typedef enum logic [MSG_W-1:0] {
        MSG_INVALIDAR  = 2'b00,
        MSG_READ_MISS  = 2'b01,
        MSG_WRITE_MISS = 2'b10,
        MSG_NENHUMA    = 2'b11
    } msg_t;

    typedef enum logic {
        OP_LEITURA = 1'b0,
        OP_ESCRITA = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_t;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        DIFUNDE = 3'd1,
        COLETA  = 3'd2,
        MEMORIA = 3'd3,
        LIBERA  = 3'd4,
        CONCLUI = 3'd5
    } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// N-way round-robin arbiter: search starts one past the last granted node.
module arbitro_rr #(
    parameter  int unsigned N     = 3,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N-1:0]     pedido,
    input  logic             avanca,
    output logic [N-1:0]     vencedor_c,
    output logic [IDX_W-1:0] indice_c,
    output logic             valido_c
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        vencedor_c = '0;
        indice_c   = '0;
        valido_c   = 1'b0;
        idx        = 0;
        for (int k = 0; k < int'(N); k++) begin
            idx = int'(ptr) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (!valido_c && pedido[IDX_W'(idx)]) begin
                valido_c              = 1'b1;
                vencedor_c[IDX_W'(idx)] = 1'b1;
                indice_c              = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (avanca && valido_c) begin
            ptr <= (indice_c == IDX_W'(N - 1)) ? '0 : indice_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/barramento_snoop.sv
// Snooping bus for MSI nodes: arbitrate, broadcast, collect aborts, run memory access.
// Optional memory-wait timeout enabled by defining BARRAMENTO_TIMEOUT_EN.
module barramento_snoop
    import barramento_pkg::*;
#(
    parameter int unsigned N_NOS  = 3,
    parameter int unsigned ADDR_W = 8
`ifdef BARRAMENTO_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CICLOS = 16
`endif
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_NOS-1:0]        req,
    input  logic [2*N_NOS-1:0]      msg_in,
    input  logic [ADDR_W*N_NOS-1:0] end_in,
    output logic [N_NOS-1:0]        grant,
    output logic [2*N_NOS-1:0]      entradaBarramento,
    output logic [ADDR_W-1:0]       end_snoop,
    input  logic [N_NOS-1:0]        writeBack_in,
    input  logic [N_NOS-1:0]        abortAccessMemory_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_end,
    input  logic                    mem_ack,
    output logic [N_NOS-1:0]        concluido,
    output logic                    ocupado
`ifdef BARRAMENTO_TIMEOUT_EN
    ,
    output logic                    erro_timeout
`endif
);

    localparam int unsigned IDX_W = $clog2(N_NOS);

    estado_t             estado, estado_nx;
    logic [N_NOS-1:0]    elegivel, vencedor_c, vencedor;
    logic [IDX_W-1:0]    indice_c;
    logic                valido_c;
    msg_t                msg_sel, msg_r;
    logic [ADDR_W-1:0]   addr_sel, addr_r;
    logic [N_NOS-1:0]    abort_out, dono;
    logic                escreve_c, expira_c;

    logic [N_NOS-1:0]    grant_d, concluido_d;
    logic [2*N_NOS-1:0]  entrada_d;
    logic [ADDR_W-1:0]   end_snoop_d, mem_end_d;
    logic                mem_req_d, mem_we_d, ocupado_d;

    // A request carrying semMensagem never competes for the bus.
    always_comb begin
        elegivel = '0;
        for (int i = 0; i < int'(N_NOS); i++) begin
            elegivel[i] = req[i] && (msg_in[2*i +: 2] != MSG_NENHUMA);
        end
    end

    arbitro_rr #(.N(N_NOS)) u_arbitro (
        .clock      (clock),
        .reset_n    (reset_n),
        .pedido     (elegivel),
        .avanca     (estado == OCIOSO),
        .vencedor_c (vencedor_c),
        .indice_c   (indice_c),
        .valido_c   (valido_c)
    );

    assign msg_sel  = msg_t'(msg_in[{indice_c, 1'b0} +: 2]);
    assign addr_sel = end_in[ADDR_W*indice_c +: ADDR_W];

    // Lowest-index aborting non-winner is the owner; its writeBack only matters alongside the abort.
    assign abort_out = abortAccessMemory_in & ~vencedor;
    assign dono      = abort_out & (~abort_out + N_NOS'(1));
    assign escreve_c = |(dono & (abortAccessMemory_in | writeBack_in));

`ifdef BARRAMENTO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [CNT_W-1:0] cont;

    assign expira_c = (cont == CNT_W'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont         <= '0;
            erro_timeout <= 1'b0;
        end else begin
            cont         <= (estado == MEMORIA) ? cont + CNT_W'(1) : '0;
            erro_timeout <= (estado == MEMORIA) && !mem_ack && expira_c;
        end
    end
`else
    assign expira_c = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= OCIOSO;
        else          estado <= estado_nx;
    end

    always_comb begin
        estado_nx = estado;
        case (estado)
            OCIOSO:  if (valido_c) estado_nx = DIFUNDE;
            DIFUNDE: estado_nx = COLETA;
            COLETA:  estado_nx = (msg_r == MSG_INVALIDAR) ? CONCLUI : MEMORIA;
            MEMORIA: if (mem_ack || expira_c) estado_nx = LIBERA;
            LIBERA:  estado_nx = CONCLUI;
            CONCLUI: estado_nx = OCIOSO;
            default: estado_nx = OCIOSO;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        grant_d     = '0;
        concluido_d = '0;
        entrada_d   = '1;
        end_snoop_d = end_snoop;
        mem_we_d    = mem_we;
        mem_end_d   = mem_end;
        mem_req_d   = (estado_nx == MEMORIA);
        ocupado_d   = (estado_nx != OCIOSO);
        case (estado_nx)
            DIFUNDE: begin
                grant_d     = vencedor_c;
                end_snoop_d = addr_sel;
                for (int j = 0; j < int'(N_NOS); j++) begin
                    entrada_d[2*j +: 2] = vencedor_c[j] ? MSG_NENHUMA : msg_sel;
                end
            end
            COLETA, MEMORIA, LIBERA: grant_d = vencedor;
            CONCLUI: concluido_d = vencedor;
            default: ;
        endcase
        if (estado == COLETA && estado_nx == MEMORIA) begin
            mem_we_d  = escreve_c;
            mem_end_d = addr_r;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vencedor          <= '0;
            msg_r             <= MSG_NENHUMA;
            addr_r            <= '0;
            grant             <= '0;
            concluido         <= '0;
            entradaBarramento <= '1;
            end_snoop         <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_end           <= '0;
            ocupado           <= 1'b0;
        end else begin
            if (estado == OCIOSO && valido_c) begin
                vencedor <= vencedor_c;
                msg_r    <= msg_sel;
                addr_r   <= addr_sel;
            end
            grant             <= grant_d;
            concluido         <= concluido_d;
            entradaBarramento <= entrada_d;
            end_snoop         <= end_snoop_d;
            mem_req           <= mem_req_d;
            mem_we            <= mem_we_d;
            mem_end           <= mem_end_d;
            ocupado           <= ocupado_d;
        end
    end

endmodule

// File: tb/tb_barramento_snoop.sv
// Bench for barramento_snoop: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_barramento_snoop;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req, grant, writeBack_in, abortAccessMemory_in, concluido;
    logic [2*N-1:0]  msg_in, entradaBarramento;
    logic [AW*N-1:0] end_in;
    logic [AW-1:0]   end_snoop, mem_end;
    logic            mem_req, mem_we, mem_ack, ocupado;
`ifdef BARRAMENTO_TIMEOUT_EN
    logic            erro_timeout;
`endif

    int errors = 0;
    int checks = 0;
    int ref_ptr = 0;

    always #5 clock = ~clock;

    barramento_snoop #(.N_NOS(N), .ADDR_W(AW)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .req                  (req),
        .msg_in               (msg_in),
        .end_in               (end_in),
        .grant                (grant),
        .entradaBarramento    (entradaBarramento),
        .end_snoop            (end_snoop),
        .writeBack_in         (writeBack_in),
        .abortAccessMemory_in (abortAccessMemory_in),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_end              (mem_end),
        .mem_ack              (mem_ack),
        .concluido            (concluido),
        .ocupado              (ocupado)
`ifdef BARRAMENTO_TIMEOUT_EN
        ,
        .erro_timeout         (erro_timeout)
`endif
    );

    typedef struct {
        int           k_grant;
        logic [N-1:0] grant;
        logic [2*N-1:0] lanes;
        logic [AW-1:0] snoop;
        bit           ocup;
        int           lanes_cycles;
        int           k_mem;
        int           mem_cycles;
        bit           read_seen;
        bit           write_seen;
        logic [AW-1:0] mend;
        int           k_conc;
        logic [N-1:0] conc;
        int           conc_cycles;
        int           k_tmo;
        logic [N-1:0] grant_after;
    } obs_t;

    // Reference: first eligible node scanning from the round-robin pointer.
    function automatic int ref_winner(input logic [N-1:0] r, input logic [2*N-1:0] m, input int ptr);
        int i;
        for (int k = 0; k < int'(N); k++) begin
            i = (ptr + k) % int'(N);
            if (r[i] && m[2*i +: 2] != 2'b11) return i;
        end
        return -1;
    endfunction

    function automatic logic [2*N-1:0] ref_lanes(input int w, input logic [1:0] m);
        logic [2*N-1:0] l;
        for (int j = 0; j < int'(N); j++) l[2*j +: 2] = (j == w) ? 2'b11 : m;
        return l;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        req = '0; msg_in = '1; end_in = '0;
        writeBack_in = '0; abortAccessMemory_in = '0; mem_ack = 1'b0;
    endtask

    // Drives the memory side and records what the bus does for one transaction.
    task automatic observe(input int ack_delay, input bit stray, input bit drop_all,
                           input int bound, output obs_t o);
        o = '{default: 0};
        o.k_grant = -1; o.k_mem = -1; o.k_conc = -1; o.k_tmo = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clock); #1;
            if (grant != '0 && o.k_grant < 0) begin
                o.k_grant = k; o.grant = grant; o.lanes = entradaBarramento;
                o.snoop = end_snoop; o.ocup = ocupado;
            end
            if (entradaBarramento != '1) o.lanes_cycles++;
            if (concluido != '0) o.conc_cycles++;
`ifdef BARRAMENTO_TIMEOUT_EN
            if (erro_timeout && o.k_tmo < 0) o.k_tmo = k;
`endif
            if (mem_req) begin
                if (o.k_mem < 0) begin o.k_mem = k; o.mend = mem_end; end
                o.mem_cycles++;
                if (mem_we) o.write_seen = 1'b1; else o.read_seen = 1'b1;
                mem_ack = (ack_delay >= 0) && (o.mem_cycles > ack_delay);
            end else begin
                mem_ack = stray && (k < 3);
            end
            if (o.k_conc >= 0) begin
                o.grant_after = grant;
                mem_ack = 1'b0;
                return;
            end
            if (concluido != '0) begin
                o.k_conc = k; o.conc = concluido;
                req = drop_all ? '0 : (req & ~concluido);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0; ref_ptr = 0;
        repeat (2) @(posedge clock); #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 000", grant); end
        checks++; if (concluido !== '0) begin errors++; $display("FAIL reset_concluido got %b want 000", concluido); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_end !== '0) begin errors++; $display("FAIL reset_mem_end got %h want 00", mem_end); end
        checks++; if (end_snoop !== '0) begin errors++; $display("FAIL reset_end_snoop got %h want 00", end_snoop); end
        checks++; if (entradaBarramento !== 6'b111111) begin errors++; $display("FAIL reset_lanes got %b want 111111", entradaBarramento); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_read_miss();
        obs_t o; int w;
        idle_inputs();
        req = 3'b010; msg_in = 6'b11_01_11; end_in = {8'h00, 8'h2A, 8'h00};
        w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
        observe(0, 1'b0, 1'b0, 20, o);
        checks++; if (o.k_grant !== 1) begin errors++; $display("FAIL rd_grant_cycle got %0d want 1", o.k_grant); end
        checks++; if (o.grant !== onehot(w)) begin errors++; $display("FAIL rd_grant got %b want %b", o.grant, onehot(w)); end
        checks++; if (o.lanes !== ref_lanes(w, 2'b01)) begin errors++; $display("FAIL rd_lanes got %b want %b", o.lanes, ref_lanes(w, 2'b01)); end
        checks++; if (o.snoop !== 8'h2A) begin errors++; $display("FAIL rd_end_snoop got %h want 2a", o.snoop); end
        checks++; if (o.ocup !== 1'b1) begin errors++; $display("FAIL rd_ocupado got %b want 1", o.ocup); end
        checks++; if (o.lanes_cycles !== 1) begin errors++; $display("FAIL rd_lane_cycles got %0d want 1", o.lanes_cycles); end
        checks++; if (o.k_mem !== 3) begin errors++; $display("FAIL rd_mem_cycle got %0d want 3", o.k_mem); end
        checks++; if ({o.read_seen, o.write_seen} !== 2'b10) begin errors++; $display("FAIL rd_mem_we got rd=%b wr=%b want rd=1 wr=0", o.read_seen, o.write_seen); end
        checks++; if (o.mend !== 8'h2A) begin errors++; $display("FAIL rd_mem_end got %h want 2a", o.mend); end
        checks++; if (o.k_conc !== 5) begin errors++; $display("FAIL rd_conc_cycle got %0d want 5", o.k_conc); end
        checks++; if (o.conc !== 3'b010) begin errors++; $display("FAIL rd_concluido got %b want 010", o.conc); end
        checks++; if (o.conc_cycles !== 1) begin errors++; $display("FAIL rd_conc_width got %0d want 1", o.conc_cycles); end
        checks++; if (o.grant_after !== '0) begin errors++; $display("FAIL rd_grant_release got %b want 000", o.grant_after); end
    endtask

    task automatic test_write_miss_abort();
        obs_t o; int w;
        idle_inputs();
        req = 3'b001; msg_in = 6'b11_11_10; end_in = {8'h00, 8'h00, 8'h10};
        abortAccessMemory_in = 3'b100; writeBack_in = 3'b100;
        w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
        observe(0, 1'b0, 1'b0, 20, o);
        checks++; if (o.grant !== 3'b001) begin errors++; $display("FAIL wm_grant got %b want 001", o.grant); end
        checks++; if (o.lanes !== 6'b10_10_11) begin errors++; $display("FAIL wm_lanes got %b want 101011", o.lanes); end
        checks++; if ({o.read_seen, o.write_seen} !== 2'b01) begin errors++; $display("FAIL wm_mem_we got rd=%b wr=%b want rd=0 wr=1", o.read_seen, o.write_seen); end
        checks++; if (o.mend !== 8'h10) begin errors++; $display("FAIL wm_mem_end got %h want 10", o.mend); end
        checks++; if (o.k_conc !== 5 || o.conc !== 3'b001) begin errors++; $display("FAIL wm_concluido got %b@%0d want 001@5", o.conc, o.k_conc); end
    endtask

    task automatic test_invalidate();
        obs_t o; int w;
        idle_inputs();
        req = 3'b100; msg_in = 6'b00_11_11; end_in = {8'h05, 8'h00, 8'h00};
        w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
        observe(0, 1'b1, 1'b0, 20, o);
        checks++; if (o.lanes !== 6'b11_00_00) begin errors++; $display("FAIL inv_lanes got %b want 110000", o.lanes); end
        checks++; if (o.snoop !== 8'h05) begin errors++; $display("FAIL inv_end_snoop got %h want 05", o.snoop); end
        checks++; if (o.mem_cycles !== 0) begin errors++; $display("FAIL inv_no_mem got %0d mem cycles want 0", o.mem_cycles); end
        checks++; if (o.k_conc !== 3) begin errors++; $display("FAIL inv_conc_cycle got %0d want 3", o.k_conc); end
        checks++; if (o.conc !== 3'b100) begin errors++; $display("FAIL inv_concluido got %b want 100", o.conc); end
    endtask

    task automatic test_round_robin();
        obs_t o; int w; int extra;
        idle_inputs();
        reset_n = 1'b0; ref_ptr = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        req = 3'b111; msg_in = 6'b01_01_01; end_in = {8'h30, 8'h20, 8'h10};
        for (int n = 0; n < int'(N); n++) begin
            w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
            observe(0, 1'b0, 1'b0, 20, o);
            checks++; if (o.grant !== onehot(n)) begin errors++; $display("FAIL rr_order_%0d got %b want %b", n, o.grant, onehot(n)); end
            checks++; if (o.conc !== onehot(w) || o.snoop !== end_in[AW*w +: AW]) begin
                errors++; $display("FAIL rr_txn_%0d got conc=%b addr=%h want conc=%b addr=%h", n, o.conc, o.snoop, onehot(w), end_in[AW*w +: AW]);
            end
        end
        extra = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (grant != '0 || concluido != '0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rr_extra_grants got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid();
        obs_t o; int w; bit seen;
        idle_inputs();
        req = 3'b010; msg_in = 6'b11_01_11; end_in = {8'h00, 8'h2A, 8'h00};
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clock); #1;
            seen = mem_req;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach got mem_req=0 want 1 within 10 cycles"); end
        reset_n = 1'b0; ref_ptr = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || grant !== '0) begin errors++; $display("FAIL rst_mid_clear got mem_req=%b grant=%b want 0/000", mem_req, grant); end
        checks++; if (entradaBarramento !== 6'b111111 || ocupado !== 1'b0) begin errors++; $display("FAIL rst_mid_lanes got %b ocup=%b want 111111/0", entradaBarramento, ocupado); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
        observe(0, 1'b0, 1'b0, 20, o);
        checks++; if (o.grant !== onehot(w) || o.conc !== onehot(w) || o.k_conc !== 5) begin
            errors++; $display("FAIL rst_mid_retry got grant=%b conc=%b@%0d want %b@5", o.grant, o.conc, o.k_conc, onehot(w));
        end
    endtask

`ifdef BARRAMENTO_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o; int w;
        idle_inputs();
        req = 3'b001; msg_in = 6'b11_11_01; end_in = {8'h00, 8'h00, 8'h77};
        w = ref_winner(req, msg_in, ref_ptr); ref_ptr = (w + 1) % int'(N);
        observe(-1, 1'b0, 1'b0, 60, o);
        checks++; if (o.mem_cycles !== 16) begin errors++; $display("FAIL tmo_mem_cycles got %0d want 16", o.mem_cycles); end
        checks++; if (o.k_tmo !== o.k_mem + 16) begin errors++; $display("FAIL tmo_erro_cycle got %0d want %0d", o.k_tmo, o.k_mem + 16); end
        checks++; if (o.k_conc !== o.k_mem + 17 || o.conc !== onehot(w)) begin errors++; $display("FAIL tmo_concluido got %b@%0d want %b@%0d", o.conc, o.k_conc, onehot(w), o.k_mem + 17); end
    endtask
`endif

    task automatic test_random();
        obs_t o; int w, delay, kc; bit stray, we;
        logic [N-1:0] r; logic [2*N-1:0] m; logic [1:0] msg; logic [AW-1:0] addr;
        for (int it = 0; it < 24; it++) begin
            idle_inputs();
            do begin
                r = N'($urandom_range(1, 7));
                m = (2*N)'($urandom);
            end while (ref_winner(r, m, ref_ptr) < 0);
            req = r; msg_in = m; end_in = (AW*N)'($urandom);
            abortAccessMemory_in = N'($urandom_range(0, 7));
            writeBack_in = N'($urandom_range(0, 7));
            delay = int'($urandom_range(0, 3));
            stray = 1'($urandom_range(0, 1));
            w = ref_winner(r, m, ref_ptr); ref_ptr = (w + 1) % int'(N);
            msg = m[2*w +: 2];
            addr = end_in[AW*w +: AW];
            we = |(abortAccessMemory_in & ~onehot(w));
            kc = (msg == 2'b00) ? 3 : 5 + delay;
            observe(delay, stray, 1'b1, 40, o);
            checks++; if (o.grant !== onehot(w) || o.k_grant !== 1) begin errors++; $display("FAIL rnd%0d_grant got %b@%0d want %b@1", it, o.grant, o.k_grant, onehot(w)); end
            checks++; if (o.lanes !== ref_lanes(w, msg) || o.snoop !== addr) begin errors++; $display("FAIL rnd%0d_broadcast got %b/%h want %b/%h", it, o.lanes, o.snoop, ref_lanes(w, msg), addr); end
            checks++; if (o.k_conc !== kc || o.conc !== onehot(w)) begin errors++; $display("FAIL rnd%0d_concluido got %b@%0d want %b@%0d", it, o.conc, o.k_conc, onehot(w), kc); end
            if (msg == 2'b00) begin
                checks++; if (o.mem_cycles !== 0) begin errors++; $display("FAIL rnd%0d_inv_mem got %0d cycles want 0", it, o.mem_cycles); end
            end else begin
                checks++; if ({o.write_seen, o.read_seen, o.mend} !== {we, ~we, addr}) begin
                    errors++; $display("FAIL rnd%0d_mem got wr=%b rd=%b end=%h want wr=%b rd=%b end=%h", it, o.write_seen, o.read_seen, o.mend, we, ~we, addr);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_read_miss();
        test_write_miss_abort();
        test_invalidate();
        test_round_robin();
        test_reset_mid();
`ifdef BARRAMENTO_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
